// File: rtl/ram_bridge_pkg.sv
// ============================================================================
// Module : ram_bridge_pkg
// Brief  : Shared constants and request type for the RAM bus bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_bridge_pkg;

  localparam int BE_WIDTH       = 4;
  localparam int REQ_ADDR_WIDTH = 10;
  localparam int REQ_DATA_WIDTH = 32;

  typedef struct packed {
    logic [REQ_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [BE_WIDTH-1:0]       be;
    logic [REQ_DATA_WIDTH-1:0] wdata;
  } ram_req_t;

endpackage

`default_nettype wire

// File: rtl/resp_fifo.sv
// ============================================================================
// Module : resp_fifo
// Brief  : Synchronous FIFO with same-cycle push/pop, count and head output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && count == FULL_CNT));
`endif

endmodule

`default_nettype wire

// File: rtl/ram_bus_bridge.sv
// ============================================================================
// Module : ram_bus_bridge
// Brief  : Valid/ready master to single-port RAM adapter with in-order reads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_bus_bridge
  import ram_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [BE_WIDTH-1:0]   req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [BE_WIDTH-1:0]   ram_be,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_w,
  input  logic [DATA_WIDTH-1:0] ram_data_r
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(RESP_DEPTH);

  logic                  accept;
  logic                  rd_inflight;
  logic                  fifo_empty;
  logic                  bypass_take;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occ;
  logic [DATA_WIDTH-1:0] fifo_head;

  // A read in flight already owns a FIFO slot, so it counts toward occupancy.
  assign occ       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_inflight};
  assign req_ready = (occ < DEPTH_LIM);
  assign accept    = req_valid & req_ready;

  assign ram_en     = accept;
  assign ram_we     = accept & req_we;
  assign ram_be     = req_be;
  assign ram_addr   = req_addr;
  assign ram_data_w = req_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= accept & ~req_we;
    end
  end

  // RAM data goes straight out when nothing older is queued ahead of it.
  assign fifo_empty  = (fifo_count == '0);
  assign resp_valid  = ~fifo_empty | rd_inflight;
  assign resp_rdata  = fifo_empty ? ram_data_r : fifo_head;
  assign bypass_take = rd_inflight & fifo_empty & resp_ready;
  assign push        = rd_inflight & ~bypass_take;
  assign pop         = ~fifo_empty & resp_ready;

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (ram_data_r),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_bridge.sv
// ============================================================================
// Module : tb_ram_bus_bridge
// Brief  : Directed self-checking bench for ram_bus_bridge with a RAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_bus_bridge;
  import ram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [9:0]  ram_addr;
  logic [31:0] ram_data_w;
  logic [31:0] ram_data_r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem [1024];
  logic [31:0] got [$];
  int          got_cyc [$];

  ram_bus_bridge #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .RESP_DEPTH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_be     (ram_be),
    .ram_addr   (ram_addr),
    .ram_data_w (ram_data_w),
    .ram_data_r (ram_data_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-first single-port RAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) mem[ram_addr][8*b +: 8] = ram_data_w[8*b +: 8];
        end
      end
      ram_data_r <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      got.push_back(resp_rdata);
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 + 32'(a) * 32'h0001_0001;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input ram_req_t r);
    int t = 0;
    req_valid = 1'b1; req_we = r.we; req_addr = r.addr;
    req_be = r.be; req_wdata = r.wdata;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL write_timeout addr %h req_ready stayed %b, required 1", r.addr, req_ready);
    end
    step();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic preload();
    ram_req_t r;
    r.we = 1'b1; r.be = 4'hF;
    r.addr = 10'h010; r.wdata = 32'hDEADBEEF; do_write(r);
    r.addr = 10'h020; r.wdata = 32'h11223344; do_write(r);
    for (int i = 0; i < 4; i++) begin
      r.addr = 10'(i); r.wdata = pat(i); do_write(r);
    end
    for (int i = 0; i < 16; i++) begin
      r.addr = 10'(16'h100 + i); r.wdata = pat(16'h100 + i); do_write(r);
    end
    for (int i = 0; i < 20; i++) begin
      r.addr = 10'(16'h200 + i); r.wdata = pat(16'h200 + i); do_write(r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_en_we got %b%b exp 00", ram_en, ram_we); end
    checks++; if (dut.rd_inflight !== 1'b0) begin errors++; $display("FAIL reset_rd_inflight got %b exp 0", dut.rd_inflight); end
    checks++; if (dut.fifo_count !== '0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", dut.fifo_count); end
    step();
  endtask

  task automatic test_single_read();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h010;
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'h010) begin
      errors++; $display("FAIL read_ram_port got en %b we %b addr %h exp 1 0 010", ram_en, ram_we, ram_addr);
    end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL idle_ram_en got %b exp 0", ram_en); end
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_read got valid %b data %h exp 1 deadbeef", resp_valid, resp_rdata);
    end
    checks++; if (dut.fifo_count !== '0) begin errors++; $display("FAIL single_read_count got %0d exp 0", dut.fifo_count); end
    step();
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_read_after got valid %b exp 0", resp_valid); end
    step();
  endtask

  task automatic test_byte_write();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h020;
    req_be = 4'b0101; req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1) begin
      errors++; $display("FAIL bw_strobe got ready %b en %b we %b exp 1 1 1", req_ready, ram_en, ram_we);
    end
    checks++; if (ram_be !== 4'b0101 || ram_data_w !== 32'hAABBCCDD || ram_addr !== 10'h020) begin
      errors++; $display("FAIL bw_fields got be %b data %h addr %h exp 0101 aabbccdd 020", ram_be, ram_data_w, ram_addr);
    end
    step();
    req_we = 1'b0;
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin
      errors++; $display("FAIL bw_read_strobe got en %b we %b exp 1 0", ram_en, ram_we);
    end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11BB33DD) begin
      errors++; $display("FAIL bw_readback got valid %b data %h exp 1 11bb33dd", resp_valid, resp_rdata);
    end
    step();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int t = 0;
    int base;
    logic acc;
    base = got.size();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = req_ready;
      if (c >= 2) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d got %b exp 0", c, req_ready); end
      end
      step();
      if (acc) begin idx++; req_addr = 10'(idx); end
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", idx); end
    @(negedge clk);
    checks++; if (dut.fifo_count !== 2'd2 || resp_valid !== 1'b1 || resp_rdata !== pat(0)) begin
      errors++; $display("FAIL bp_held got count %0d valid %b data %h exp 2 1 %h", dut.fifo_count, resp_valid, resp_rdata, pat(0));
    end
    step();
    resp_ready = 1'b1;
    while (idx < 4 && t < 30) begin
      @(negedge clk);
      acc = req_ready;
      step();
      t++;
      if (acc) begin idx++; req_addr = 10'(idx); end
    end
    req_valid = 1'b0;
    checks++; if (idx != 4) begin errors++; $display("FAIL bp_drain_timeout got %0d accepted exp 4", idx); end
    repeat (4) step();
    checks++; if (got.size() - base != 4) begin errors++; $display("FAIL bp_resp_count got %0d exp 4", got.size() - base); end
    for (int i = 0; i < 4 && base + i < got.size(); i++) begin
      checks++; if (got[base+i] !== pat(i)) begin errors++; $display("FAIL bp_order idx %0d got %h exp %h", i, got[base+i], pat(i)); end
    end
  endtask

  task automatic test_streaming();
    int base;
    int low = 0;
    base = got.size();
    resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'(16'h100 + i);
      @(negedge clk);
      if (req_ready !== 1'b1) low++;
      step();
    end
    req_valid = 1'b0;
    repeat (3) step();
    checks++; if (low != 0) begin errors++; $display("FAIL stream_ready got %0d low cycles exp 0", low); end
    checks++; if (got.size() - base != 16) begin errors++; $display("FAIL stream_count got %0d exp 16", got.size() - base); end
    for (int i = 0; i < 16 && base + i < got.size(); i++) begin
      checks++; if (got[base+i] !== pat(16'h100 + i)) begin
        errors++; $display("FAIL stream_data idx %0d got %h exp %h", i, got[base+i], pat(16'h100 + i));
      end
      if (i > 0) begin
        checks++; if (got_cyc[base+i] != got_cyc[base] + i) begin
          errors++; $display("FAIL stream_gap idx %0d got cycle %0d exp %0d", i, got_cyc[base+i], got_cyc[base] + i);
        end
      end
    end
  endtask

  task automatic test_back_to_back_toggle();
    int base;
    int idx = 0;
    int t = 0;
    logic acc;
    base = got.size();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h200;
    while (idx < 20 && t < 200) begin
      @(negedge clk);
      acc = req_ready;
      step();
      t++;
      resp_ready = ~resp_ready;
      if (acc) begin idx++; req_addr = 10'(16'h200 + idx); end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (4) step();
    checks++; if (idx != 20) begin errors++; $display("FAIL toggle_timeout got %0d accepted exp 20", idx); end
    checks++; if (got.size() - base != 20) begin errors++; $display("FAIL toggle_count got %0d exp 20", got.size() - base); end
    for (int i = 0; i < 20 && base + i < got.size(); i++) begin
      checks++; if (got[base+i] !== pat(16'h200 + i)) begin
        errors++; $display("FAIL toggle_order idx %0d got %h exp %h", i, got[base+i], pat(16'h200 + i));
      end
    end
  endtask

  task automatic test_reset_midop();
    int base;
    base = got.size();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h000;
    @(negedge clk);
    step();
    req_addr = 10'h001;
    @(negedge clk);
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (dut.fifo_count !== 2'd1 || dut.rd_inflight !== 1'b1) begin
      errors++; $display("FAIL midop_setup got count %0d inflight %b exp 1 1", dut.fifo_count, dut.rd_inflight);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midop_resp_valid got %b exp 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midop_req_ready got %b exp 1", req_ready); end
    checks++; if (dut.fifo_count !== '0) begin errors++; $display("FAIL midop_count got %0d exp 0", dut.fifo_count); end
    step();
    resp_ready = 1'b1;
    repeat (4) step();
    checks++; if (got.size() != base) begin errors++; $display("FAIL midop_stale got %0d responses exp 0", got.size() - base); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    preload();
    test_single_read();
    test_byte_write();
    test_backpressure();
    test_streaming();
    test_back_to_back_toggle();
    test_reset_midop();
    test_single_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
